// File: rtl/gate_bus_pkg.sv
// Shared definitions for the pipelined gate bus: operation encodings,
// accumulator state encodings and a saturating beat-count helper.
package gate_bus_pkg;

  // Base operation encodings carried in op[1:0]; 2'b11 is a second OR code.
  localparam logic [1:0] OP_AND    = 2'b00;
  localparam logic [1:0] OP_OR     = 2'b01;
  localparam logic [1:0] OP_XOR    = 2'b10;
  localparam logic [1:0] OP_OR_ALT = 2'b11;

  // Bit position of the "invert final result" flag inside the 3-bit op.
  localparam int OP_INV = 2;

  // Accumulator FSM states.
  localparam logic [0:0] ACC_IDLE = 1'b0;
  localparam logic [0:0] ACC_OPEN = 1'b1;

  // Beat counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gate_bus_reduce.sv
// Combinational lane reduction: invert the lanes selected by BubblesMask,
// then fold all lanes together bitwise with the selected base operation.
module gate_bus_reduce
  import gate_bus_pkg::*;
#(
  parameter int                    NrOfBits    = 8,
  parameter int                    NrOfInputs  = 4,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
  input  logic [NrOfInputs*NrOfBits-1:0] data,
  input  logic [1:0]                     op,
  output logic [NrOfBits-1:0]            reduced
);

  logic [NrOfBits-1:0] w_acc;
  logic [NrOfBits-1:0] w_lane;

  // Fold lanes 1..N-1 into lane 0, applying each lane's bubble first.
  always_comb begin
    w_lane = '0;
    w_acc  = data[NrOfBits-1:0] ^ {NrOfBits{BubblesMask[0]}};
    for (int i = 1; i < NrOfInputs; i++) begin
      w_lane = data[i*NrOfBits +: NrOfBits] ^ {NrOfBits{BubblesMask[i]}};
      case (op)
        OP_AND:  w_acc = w_acc & w_lane;
        OP_XOR:  w_acc = w_acc ^ w_lane;
        default: w_acc = w_acc | w_lane;
      endcase
    end
    reduced = w_acc;
  end

endmodule

// File: rtl/pipelined_gate_bus.sv
// Pipelined gate bus: reduces NrOfInputs lanes per beat, optionally folds
// several beats into one packet result, and presents results through a
// 2-entry skid buffer.
//
// Handshake: a beat moves when inValid && inReady at a rising edge; a result
// moves when outValid && outReady at a rising edge. inReady is a register
// meaning "skid entry empty", so it never depends on outReady in the same
// cycle, and outData/outBeats hold while outValid && !outReady.
module pipelined_gate_bus
  import gate_bus_pkg::*;
#(
  parameter int                    NrOfBits    = 8,
  parameter int                    NrOfInputs  = 4,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [NrOfInputs*NrOfBits-1:0] inData,
  input  logic [2:0]                     inOp,
  input  logic                           inAccumulate,
  input  logic                           inLast,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [NrOfBits-1:0]            outData,
  output logic [7:0]                     outBeats,
  output logic [0:0]                     o_dbg_acc_state
);

  // Accumulator state
  logic [0:0]          r_acc_state;
  logic [NrOfBits-1:0] r_acc;
  logic [2:0]          r_acc_op;
  logic [7:0]          r_acc_beats;

  // Skid buffer: r_out_* is the head presented on the output port,
  // r_skid_* holds the younger result while the head is stalled.
  logic                r_out_valid;
  logic [NrOfBits-1:0] r_out_data;
  logic [7:0]          r_out_beats;
  logic                r_skid_valid;
  logic [NrOfBits-1:0] r_skid_data;
  logic [7:0]          r_skid_beats;
  logic                r_in_ready;

  logic                w_in_xfer;
  logic                w_pop;
  logic                w_acc_beat;
  logic [1:0]          w_red_op;
  logic [NrOfBits-1:0] w_reduced;
  logic [NrOfBits-1:0] w_acc_data;
  logic [7:0]          w_acc_beats;
  logic                w_acc_inv;
  logic                w_push;
  logic [NrOfBits-1:0] w_push_data;
  logic [7:0]          w_push_beats;

  assign w_in_xfer  = inValid & r_in_ready;
  assign w_pop      = r_out_valid & outReady;
  assign w_acc_beat = w_in_xfer & inAccumulate;

  // Continuing packet beats reduce with the op captured on the first beat.
  assign w_red_op = ((r_acc_state == ACC_OPEN) && inAccumulate) ? r_acc_op[1:0] : inOp[1:0];

  gate_bus_reduce #(
    .NrOfBits    (NrOfBits),
    .NrOfInputs  (NrOfInputs),
    .BubblesMask (BubblesMask)
  ) u_reduce (
    .data    (inData),
    .op      (w_red_op),
    .reduced (w_reduced)
  );

  // Next accumulator value and the result (if any) produced by this beat.
  always_comb begin
    w_acc_data   = w_reduced;
    w_acc_beats  = 8'd1;
    w_acc_inv    = inOp[OP_INV];
    w_push       = 1'b0;
    w_push_data  = w_reduced ^ {NrOfBits{inOp[OP_INV]}};
    w_push_beats = 8'd1;
    if (r_acc_state == ACC_OPEN) begin
      case (r_acc_op[1:0])
        OP_AND:  w_acc_data = r_acc & w_reduced;
        OP_XOR:  w_acc_data = r_acc ^ w_reduced;
        default: w_acc_data = r_acc | w_reduced;
      endcase
      w_acc_beats = sat_inc(r_acc_beats);
      w_acc_inv   = r_acc_op[OP_INV];
    end
    if (w_in_xfer) begin
      if (!inAccumulate) begin
        w_push = 1'b1;
      end else if (inLast) begin
        w_push       = 1'b1;
        w_push_data  = w_acc_data ^ {NrOfBits{w_acc_inv}};
        w_push_beats = w_acc_beats;
      end
    end
  end

  // Accumulator FSM: open on the first packet beat, close on inLast.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_acc_state <= ACC_IDLE;
      r_acc       <= '0;
      r_acc_op    <= '0;
      r_acc_beats <= '0;
    end else if (w_acc_beat) begin
      if (inLast) begin
        r_acc_state <= ACC_IDLE;
        r_acc       <= '0;
        r_acc_beats <= '0;
      end else begin
        r_acc_state <= ACC_OPEN;
        r_acc       <= w_acc_data;
        r_acc_beats <= w_acc_beats;
        if (r_acc_state == ACC_IDLE) begin
          r_acc_op <= inOp;
        end
      end
    end
  end

  // Skid buffer: refill the head from skid first, spill into skid on stall.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_beats  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_beats <= '0;
      r_in_ready   <= 1'b0;
    end else if (r_skid_valid) begin
      // inReady is low here, so no push can arrive alongside.
      if (w_pop) begin
        r_out_data   <= r_skid_data;
        r_out_beats  <= r_skid_beats;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end
    end else if (w_push) begin
      if (!r_out_valid || w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_push_data;
        r_out_beats <= w_push_beats;
        r_in_ready  <= 1'b1;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_push_data;
        r_skid_beats <= w_push_beats;
        r_in_ready   <= 1'b0;
      end
    end else begin
      if (w_pop) begin
        r_out_valid <= 1'b0;
      end
      r_in_ready <= 1'b1;
    end
  end

  assign inReady         = r_in_ready;
  assign outValid        = r_out_valid;
  assign outData         = r_out_data;
  assign outBeats        = r_out_beats;
  assign o_dbg_acc_state = r_acc_state;

endmodule

// File: tb/tb_pipelined_gate_bus.sv
// Self-checking bench for pipelined_gate_bus (8-bit lanes, 4 lanes).
// A second instance with lane 0 bubbled covers the mask path.
module tb_pipelined_gate_bus;

  // Clock / reset
  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  // Main DUT signals (mask 0)
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inData = '0;
  logic [2:0]  inOp = '0;
  logic        inAccumulate = 1'b0;
  logic        inLast = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [7:0]  outData;
  logic [7:0]  outBeats;
  logic [0:0]  dbg_state;

  // Masked DUT signals (mask 4'b0001)
  logic        m_inValid = 1'b0;
  logic        m_inReady;
  logic [31:0] m_inData = '0;
  logic [2:0]  m_inOp = '0;
  logic        m_inAccumulate = 1'b0;
  logic        m_inLast = 1'b0;
  logic        m_outValid;
  logic        m_outReady = 1'b1;
  logic [7:0]  m_outData;
  logic [7:0]  m_outBeats;
  logic [0:0]  m_dbg_state;

  pipelined_gate_bus #(.NrOfBits(8), .NrOfInputs(4), .BubblesMask(4'b0000)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inOp(inOp), .inAccumulate(inAccumulate), .inLast(inLast),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outBeats(outBeats), .o_dbg_acc_state(dbg_state)
  );

  pipelined_gate_bus #(.NrOfBits(8), .NrOfInputs(4), .BubblesMask(4'b0001)) dut_m (
    .clock(clock), .resetN(resetN), .inValid(m_inValid), .inReady(m_inReady),
    .inData(m_inData), .inOp(m_inOp), .inAccumulate(m_inAccumulate), .inLast(m_inLast),
    .outValid(m_outValid), .outReady(m_outReady), .outData(m_outData),
    .outBeats(m_outBeats), .o_dbg_acc_state(m_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {beats, data} of every result the DUT still owes.
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference reduction (no final inversion).
  function automatic logic [7:0] model_reduce(input logic [31:0] d, input logic [1:0] op,
                                              input logic [3:0] mask);
    logic [7:0] r;
    logic [7:0] l;
    r = d[7:0] ^ {8{mask[0]}};
    for (int i = 1; i < 4; i++) begin
      l = d[i*8 +: 8] ^ {8{mask[i]}};
      case (op)
        2'b00:   r = r & l;
        2'b10:   r = r ^ l;
        default: r = r | l;
      endcase
    end
    return r;
  endfunction

  // Monitor: pop and compare each transferred result; check hold stability.
  logic        hold_valid = 1'b0;
  logic [15:0] hold_val = '0;
  always @(negedge clock) begin
    if (hold_valid && outValid) check("hold_stable", {16'h0, outBeats, outData}, {16'h0, hold_val});
    if (outValid && outReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h, expected no result", {outBeats, outData});
      end else begin
        check("out", {16'h0, outBeats, outData}, {16'h0, exp_q.pop_front()});
      end
    end
    hold_valid = outValid && !outReady;
    hold_val   = {outBeats, outData};
  end

  // Driver: offer one beat, wait (bounded) for inReady, return after transfer edge.
  task automatic send_beat(input logic [31:0] d, input logic [2:0] op, input logic acc,
                           input logic last, output int stalls);
    inValid = 1'b1; inData = d; inOp = op; inAccumulate = acc; inLast = last;
    stalls = 0;
    while (!inReady && stalls < 200) begin
      @(posedge clock); #1;
      stalls++;
      if (stalls > 4) outReady = 1'b1;
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got inReady 0, expected 1 within 200 cycles");
    end else begin
      @(posedge clock); #1;
    end
    inValid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic m_send(input string name, input logic [31:0] d, input logic [2:0] op,
                        input logic [7:0] exp);
    check({name, "_ready"}, {31'h0, m_inReady}, 1);
    m_inValid = 1'b1; m_inData = d; m_inOp = op;
    @(posedge clock); #1;
    m_inValid = 1'b0;
    check({name, "_valid"}, {31'h0, m_outValid}, 1);
    check({name, "_data"}, {24'h0, m_outData}, {24'h0, exp});
    check({name, "_beats"}, {24'h0, m_outBeats}, 1);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [2:0]  op;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[9];

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int st;
    int total;
    logic [31:0] d;
    logic [7:0]  acc;

    vecs[0] = '{32'h0000F00F, 3'b001, 8'hFF};
    vecs[1] = '{32'hFFFFFFFF, 3'b000, 8'hFF};
    vecs[2] = '{32'hFF0FFFFF, 3'b000, 8'h0F};
    vecs[3] = '{32'h01020408, 3'b010, 8'h0F};
    vecs[4] = '{32'h01020408, 3'b011, 8'h0F};
    vecs[5] = '{32'h00000000, 3'b101, 8'hFF};
    vecs[6] = '{32'h11111101, 3'b110, 8'hEF};
    vecs[7] = '{32'hA5A5A5A5, 3'b100, 8'h5A};
    vecs[8] = '{32'h80000001, 3'b011, 8'h81};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", {31'h0, outValid}, 0);
    check("rst_data", {24'h0, outData}, 0);
    check("rst_beats", {24'h0, outBeats}, 0);
    check("rst_ready", {31'h0, inReady}, 0);
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", {31'h0, inReady}, 1);
    check("m_ready_after_reset", {31'h0, m_inReady}, 1);

    // Single-beat table, latency 1
    foreach (vecs[i]) begin
      send_beat(vecs[i].data, vecs[i].op, 1'b0, 1'b0, st);
      exp_q.push_back({8'd1, vecs[i].exp});
      check($sformatf("vec%0d_valid", i), {31'h0, outValid}, 1);
      check($sformatf("vec%0d_data", i), {24'h0, outData}, {24'h0, vecs[i].exp});
      check($sformatf("vec%0d_beats", i), {24'h0, outBeats}, 1);
    end
    wait_drain();

    // Bubble mask on lane 0
    m_send("mask_nand", 32'h00000000, 3'b100, 8'hFF);
    m_send("mask_and", 32'hFFFFFF00, 3'b000, 8'hFF);
    m_send("mask_xor", 32'h00000000, 3'b010, 8'hFF);
    m_send("mask_or", 32'h000000FF, 3'b001, 8'h00);
    check("m_dbg_idle", {31'h0, m_dbg_state}, 0);

    // Back-to-back throughput with outReady high
    total = 0;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      inOp = 3'($urandom_range(0, 7));
      send_beat(d, inOp, 1'b0, 1'b0, st);
      total += st;
      exp_q.push_back({8'd1, model_reduce(d, inOp[1:0], 4'b0) ^ {8{inOp[2]}}});
    end
    check("throughput_stalls", total, 0);
    wait_drain();

    // Backpressure: two results held, inReady falls, then ordered drain
    outReady = 1'b0;
    send_beat(32'h000000AA, 3'b001, 1'b0, 1'b0, st);
    exp_q.push_back({8'd1, 8'hAA});
    send_beat(32'h0000BB00, 3'b001, 1'b0, 1'b0, st);
    exp_q.push_back({8'd1, 8'hBB});
    inValid = 1'b1; inData = 32'h00CC0000; inOp = 3'b001; inAccumulate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("full_ready_low", {31'h0, inReady}, 0);
      check("full_valid", {31'h0, outValid}, 1);
      check("full_head", {24'h0, outData}, 32'hAA);
      @(posedge clock); #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    send_beat(32'h00CC0000, 3'b001, 1'b0, 1'b0, st);
    exp_q.push_back({8'd1, 8'hCC});
    wait_drain();

    // Accumulate XOR; op change mid-packet ignored
    send_beat(32'h00000001, 3'b010, 1'b1, 1'b0, st);
    check("acc_no_out1", {31'h0, outValid}, 0);
    check("acc_open", {31'h0, dbg_state}, 1);
    send_beat(32'h00000002, 3'b000, 1'b1, 1'b0, st);
    check("acc_no_out2", {31'h0, outValid}, 0);
    send_beat(32'h00000004, 3'b000, 1'b1, 1'b1, st);
    exp_q.push_back({8'd3, 8'h07});
    check("acc_idle", {31'h0, dbg_state}, 0);
    wait_drain();

    // Single beat inside an open packet
    send_beat(32'h00000010, 3'b010, 1'b1, 1'b0, st);
    send_beat(32'h0000000F, 3'b001, 1'b0, 1'b0, st);
    exp_q.push_back({8'd1, 8'h0F});
    send_beat(32'h00000020, 3'b010, 1'b1, 1'b1, st);
    exp_q.push_back({8'd2, 8'h30});
    wait_drain();

    // Beat counter saturation
    acc = '0;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      send_beat(d, 3'b010, 1'b1, (i == 299), st);
      acc ^= model_reduce(d, 2'b10, 4'b0);
    end
    exp_q.push_back({8'd255, acc});
    wait_drain();

    // Reset mid-packet with a held result
    outReady = 1'b0;
    send_beat(32'h00000033, 3'b001, 1'b0, 1'b0, st);
    send_beat(32'h00000010, 3'b010, 1'b1, 1'b0, st);
    send_beat(32'h00000020, 3'b010, 1'b1, 1'b0, st);
    #2 resetN = 1'b0;
    #1;
    check("midrst_valid", {31'h0, outValid}, 0);
    check("midrst_data", {24'h0, outData}, 0);
    check("midrst_beats", {24'h0, outBeats}, 0);
    check("midrst_ready", {31'h0, inReady}, 0);
    check("midrst_state", {31'h0, dbg_state}, 0);
    @(negedge clock);
    resetN = 1'b1;
    outReady = 1'b1;
    @(posedge clock); #1;
    check("midrst_ready_up", {31'h0, inReady}, 1);
    send_beat(32'h00000040, 3'b010, 1'b1, 1'b1, st);
    exp_q.push_back({8'd1, 8'h40});
    wait_drain();

    repeat (3) @(posedge clock);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
